// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: FSM encoding, scan-code prefixes,
// frame geometry and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    // True when data plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Single-clock FIFO with combinational head; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == LW'(DEPTH));
    assign empty     = (count_r == LW'(0));
    assign level     = count_r;
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign pop_data  = empty ? WIDTH'(0) : mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= LW'(0);
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + LW'(1);
            end else if (pop_ok_s && !push_ok_s) begin
                count_r <= count_r - LW'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame FSM with timeout,
// error pulses and a ready/valid FIFO. Define PS2_SCAN_DECODE_EN to fold E0/F0 into tags.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          i_clk,
    input  logic                          i_clr_n,
    input  logic                          i_ps2_clk,
    input  logic                          i_ps2_data,
    input  logic                          i_ready,
    input  logic                          i_ovf_clr,
    output logic                          o_valid,
    output logic [7:0]                    o_data,
    output logic                          o_ext,
    output logic                          o_brk,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    output logic                          o_parity_err,
    output logic                          o_frame_err,
    output logic                          o_timeout
);

`ifdef PS2_SCAN_DECODE_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif
    localparam int FW        = $clog2(FILTER_LEN + 1);
    localparam int TW        = $clog2(TIMEOUT_CYC + 1);
    localparam int DATA_BITS = PS2_FRAME_BITS - 3;

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_synced_s;
    logic                   data_synced_s;
    logic                   filt_clk_r;
    logic                   filt_clk_nxt_s;
    logic [FW-1:0]          filt_cnt_r;
    logic [FW-1:0]          filt_cnt_nxt_s;
    logic                   strobe_s;

    ps2_state_e    state_r, state_nxt_s;
    logic [2:0]    bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]    shift_r, shift_nxt_s;
    logic          par_r, par_nxt_s;
    logic [TW-1:0] tcnt_r, tcnt_nxt_s;
    logic          push_r, push_nxt_s;
    logic [EW-1:0] push_word_r, push_word_nxt_s;
    logic          frame_err_nxt_s;
    logic          parity_err_nxt_s;
    logic          timeout_nxt_s;
`ifdef PS2_SCAN_DECODE_EN
    logic          ext_r, ext_nxt_s;
    logic          brk_r, brk_nxt_s;
`endif

    logic [EW-1:0] head_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          drop_s;
    logic          ovf_r;

    assign clk_synced_s  = clk_sync_r[SYNC_STAGES-1];
    assign data_synced_s = data_sync_r[SYNC_STAGES-1];

    // Metastability chains; idle bus level is high.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], i_ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], i_ps2_data};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_clk_nxt_s = filt_clk_r;
        filt_cnt_nxt_s = FW'(0);
        if (clk_synced_s != filt_clk_r) begin
            if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
                filt_clk_nxt_s = ~filt_clk_r;
                filt_cnt_nxt_s = FW'(0);
            end else begin
                filt_cnt_nxt_s = filt_cnt_r + FW'(1);
            end
        end else begin
            filt_cnt_nxt_s = FW'(0);
        end
    end

    assign strobe_s = filt_clk_r & ~filt_clk_nxt_s;

    // Filter state register.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= FW'(0);
        end else begin
            filt_clk_r <= filt_clk_nxt_s;
            filt_cnt_r <= filt_cnt_nxt_s;
        end
    end

    // Frame FSM next state, timeout and push/error decisions.
    always_comb begin
        state_nxt_s      = state_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        shift_nxt_s      = shift_r;
        par_nxt_s        = par_r;
        tcnt_nxt_s       = tcnt_r;
        push_nxt_s       = 1'b0;
        push_word_nxt_s  = EW'(shift_r);
        frame_err_nxt_s  = 1'b0;
        parity_err_nxt_s = 1'b0;
        timeout_nxt_s    = 1'b0;
`ifdef PS2_SCAN_DECODE_EN
        ext_nxt_s        = ext_r;
        brk_nxt_s        = brk_r;
`endif
        if (state_r == ST_IDLE || strobe_s) begin
            tcnt_nxt_s = TW'(0);
        end else begin
            tcnt_nxt_s = tcnt_r + TW'(1);
        end

        case (state_r)
            ST_IDLE: begin
                if (strobe_s) begin
                    if (!data_synced_s) begin
                        state_nxt_s   = ST_DATA;
                        bit_cnt_nxt_s = 3'd0;
                    end else begin
                        frame_err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (strobe_s) begin
                    shift_nxt_s   = {data_synced_s, shift_r[7:1]};
                    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
                        state_nxt_s = ST_PARITY;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (strobe_s) begin
                    par_nxt_s   = data_synced_s;
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (strobe_s) begin
                    state_nxt_s = ST_IDLE;
                    if (!data_synced_s) begin
                        frame_err_nxt_s = 1'b1;
                    end else if (!odd_parity_ok(shift_r, par_r)) begin
                        parity_err_nxt_s = 1'b1;
                    end else begin
`ifdef PS2_SCAN_DECODE_EN
                        if (shift_r == PS2_PREFIX_EXT) begin
                            ext_nxt_s = 1'b1;
                        end else if (shift_r == PS2_PREFIX_BRK) begin
                            brk_nxt_s = 1'b1;
                        end else begin
                            push_nxt_s      = 1'b1;
                            push_word_nxt_s = {ext_r, brk_r, shift_r};
                            ext_nxt_s       = 1'b0;
                            brk_nxt_s       = 1'b0;
                        end
`else
                        push_nxt_s      = 1'b1;
                        push_word_nxt_s = shift_r;
`endif
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // A stalled frame is abandoned; no strobe can coincide with this.
        if (state_r != ST_IDLE && !strobe_s && tcnt_r == TW'(TIMEOUT_CYC - 1)) begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = 3'd0;
            tcnt_nxt_s    = TW'(0);
            timeout_nxt_s = 1'b1;
        end else begin
            timeout_nxt_s = 1'b0;
        end
`ifdef PS2_SCAN_DECODE_EN
        if (frame_err_nxt_s || timeout_nxt_s) begin
            ext_nxt_s = 1'b0;
            brk_nxt_s = 1'b0;
        end else begin
            ext_nxt_s = ext_nxt_s;
            brk_nxt_s = brk_nxt_s;
        end
`endif
    end

    // Frame FSM registers and error pulses.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'd0;
            par_r        <= 1'b0;
            tcnt_r       <= TW'(0);
            push_r       <= 1'b0;
            push_word_r  <= EW'(0);
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_timeout    <= 1'b0;
`ifdef PS2_SCAN_DECODE_EN
            ext_r        <= 1'b0;
            brk_r        <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            shift_r      <= shift_nxt_s;
            par_r        <= par_nxt_s;
            tcnt_r       <= tcnt_nxt_s;
            push_r       <= push_nxt_s;
            push_word_r  <= push_word_nxt_s;
            o_frame_err  <= frame_err_nxt_s;
            o_parity_err <= parity_err_nxt_s;
            o_timeout    <= timeout_nxt_s;
`ifdef PS2_SCAN_DECODE_EN
            ext_r        <= ext_nxt_s;
            brk_r        <= brk_nxt_s;
`endif
        end
    end

    assign pop_s  = i_ready & ~empty_s;
    assign drop_s = push_r & full_s & ~pop_s;

    ps2_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_clr_n),
        .push      (push_r),
        .push_data (push_word_r),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (o_level)
    );

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign o_overflow = ovf_r;
    assign o_valid    = ~empty_s;
    assign o_data     = head_s[7:0];
`ifdef PS2_SCAN_DECODE_EN
    assign o_ext      = head_s[9];
    assign o_brk      = head_s[8];
`else
    assign o_ext      = 1'b0;
    assign o_brk      = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised bench for ps2_rx_fifo against a frame-level queue model; build with
// PS2_SCAN_DECODE_EN defined to exercise prefix tagging.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TO    = 1000;
    localparam int HALF  = 20;

    logic       i_clk = 1'b0;
    logic       i_clr_n, i_ps2_clk, i_ps2_data, i_ready, i_ovf_clr;
    logic       o_valid, o_ext, o_brk, o_overflow, o_parity_err, o_frame_err, o_timeout;
    logic [7:0] o_data;
    logic [$clog2(DEPTH):0] o_level;

    int n_chk = 0, n_pass = 0;
    int par_seen = 0, frm_seen = 0, to_seen = 0;
    int exp_par = 0, exp_frm = 0, exp_to = 0;
    logic [9:0] exp_q[$];
    logic exp_ovf = 1'b0;
    int lat = 0;
`ifdef PS2_SCAN_DECODE_EN
    logic pend_ext = 1'b0, pend_brk = 1'b0;
`endif

    ps2_rx_fifo #(
        .FIFO_DEPTH (DEPTH), .SYNC_STAGES (2), .FILTER_LEN (4), .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk (i_clk), .i_clr_n (i_clr_n), .i_ps2_clk (i_ps2_clk), .i_ps2_data (i_ps2_data),
        .i_ready (i_ready), .i_ovf_clr (i_ovf_clr), .o_valid (o_valid), .o_data (o_data),
        .o_ext (o_ext), .o_brk (o_brk), .o_level (o_level), .o_overflow (o_overflow),
        .o_parity_err (o_parity_err), .o_frame_err (o_frame_err), .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Count high cycles of each pulse output; one event must give exactly one cycle.
    always @(negedge i_clk) begin
        if (i_clr_n === 1'b1) begin
            if (o_parity_err) par_seen = par_seen + 1;
            if (o_frame_err)  frm_seen = frm_seen + 1;
            if (o_timeout)    to_seen  = to_seen + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, then a low half period.
    task automatic drive_bit(input logic b, input bit glitch, input int ready_at,
                             input int clr_at, input bit measure);
        logic [$clog2(DEPTH):0] lvl0;
        i_ps2_data = b;
        if (glitch) begin
            tick(HALF/2 - 4); i_ps2_clk = 1'b0; tick(2); i_ps2_clk = 1'b1; tick(HALF/2 + 2);
        end else begin
            tick(HALF);
        end
        lvl0 = o_level;
        i_ps2_clk = 1'b0;
        for (int c = 1; c <= HALF; c++) begin
            i_ready   = (c == ready_at);
            i_ovf_clr = (c == clr_at);
            @(posedge i_clk); #1;
            i_ready   = 1'b0;
            i_ovf_clr = 1'b0;
            if (measure && lat == 0 && o_level != lvl0) lat = c;
        end
        i_ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input logic stop,
                              input bit glitch, input int ready_at, input int clr_at, input bit measure);
        logic par;
        par = ~(^d) ^ par_flip;
        drive_bit(1'b0, glitch, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], glitch, 0, 0, 1'b0);
        drive_bit(par, glitch, 0, 0, 1'b0);
        drive_bit(stop, glitch, ready_at, clr_at, measure);
        i_ps2_data = 1'b1;
        tick(10);
    endtask

    task automatic model_enq(input logic [9:0] e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit par_flip, input logic stop);
        if (!stop) begin
            exp_frm++;
`ifdef PS2_SCAN_DECODE_EN
            pend_ext = 1'b0; pend_brk = 1'b0;
`endif
        end else if (par_flip) begin
            exp_par++;
        end else begin
`ifdef PS2_SCAN_DECODE_EN
            if (d == 8'hE0) pend_ext = 1'b1;
            else if (d == 8'hF0) pend_brk = 1'b1;
            else begin
                model_enq({pend_ext, pend_brk, d});
                pend_ext = 1'b0; pend_brk = 1'b0;
            end
`else
            model_enq({2'b00, d});
`endif
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
`ifdef PS2_SCAN_DECODE_EN
        pend_ext = 1'b0; pend_brk = 1'b0;
`endif
    endtask

    task automatic check_state(input string tag);
        logic [9:0] h;
        h = (exp_q.size() > 0) ? exp_q[0] : 10'h000;
        chk({tag, ":valid"}, 32'(o_valid), 32'(exp_q.size() > 0));
        chk({tag, ":level"}, 32'(o_level), 32'(exp_q.size()));
        chk({tag, ":data"},  32'(o_data),  32'(h[7:0]));
        chk({tag, ":ext"},   32'(o_ext),   32'(h[9]));
        chk({tag, ":brk"},   32'(o_brk),   32'(h[8]));
        chk({tag, ":ovf"},   32'(o_overflow), 32'(exp_ovf));
        chk({tag, ":perr"},  32'(par_seen), 32'(exp_par));
        chk({tag, ":ferr"},  32'(frm_seen), 32'(exp_frm));
        chk({tag, ":tmo"},   32'(to_seen),  32'(exp_to));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ":valid"}, 32'(o_valid), 32'd0);
        chk({tag, ":data"},  32'(o_data),  32'd0);
        chk({tag, ":ext"},   32'(o_ext),   32'd0);
        chk({tag, ":brk"},   32'(o_brk),   32'd0);
        chk({tag, ":level"}, 32'(o_level), 32'd0);
        chk({tag, ":ovf"},   32'(o_overflow), 32'd0);
        chk({tag, ":pulses"}, 32'({o_parity_err, o_frame_err, o_timeout}), 32'd0);
    endtask

    task automatic read_one(input string tag);
        logic [9:0] h;
        h = exp_q.pop_front();
        chk({tag, ":head"}, 32'(o_data), 32'(h[7:0]));
        chk({tag, ":hext"}, 32'(o_ext),  32'(h[9]));
        chk({tag, ":hbrk"}, 32'(o_brk),  32'(h[8]));
        i_ready = 1'b1; tick(1); i_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) read_one(tag);
        check_state({tag, "_empty"});
    endtask

    task automatic fill(input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom_range(0, 8'hDF));
            send_frame(d, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
            model_frame(d, 1'b0, 1'b1);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] tail;
        logic [9:0] h;
        int         e, nr;
        bit         pf, g;
        logic       st;

        i_clr_n = 1'b0; i_ps2_clk = 1'b1; i_ps2_data = 1'b1; i_ready = 1'b0; i_ovf_clr = 1'b0;
        tick(5);
        check_zero("reset");
        i_clr_n = 1'b1;
        tick(5);

        // Single frame, latency calibration, pop, ready while empty.
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
        model_frame(8'h1C, 1'b0, 1'b1);
        chk("push_seen", 32'(lat > 0 && lat < HALF), 32'd1);
        check_state("one");
        read_one("one_rd");
        check_state("one_pop");
        i_ready = 1'b1; tick(1); i_ready = 1'b0;
        check_state("rdy_empty");

        // Overflow on the 9th frame, with a clear landing on the drop cycle.
        fill(8);
        tail = 8'($urandom_range(0, 8'hDF));
        send_frame(tail, 1'b0, 1'b1, 1'b0, 0, lat, 1'b0);
        model_frame(tail, 1'b0, 1'b1);
        check_state("full");
        i_ovf_clr = 1'b1; tick(1); i_ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check_state("ovf_clr");
        drain("full_rd");

        // Parity and stop-bit errors.
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        model_frame(8'h1C, 1'b1, 1'b1);
        check_state("perr");
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        model_frame(8'h1C, 1'b0, 1'b0);
        check_state("ferr");

        // Prefix, then a stalled frame, then recovery.
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        model_frame(8'hE0, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0], 1'b0, 0, 0, 1'b0);
        tick(TO - 100);
        chk("tmo_early", 32'(to_seen), 32'(exp_to));
        tick(200);
        exp_to++;
`ifdef PS2_SCAN_DECODE_EN
        pend_ext = 1'b0; pend_brk = 1'b0;
`endif
        check_state("tmo");
        send_frame(8'h32, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        model_frame(8'h32, 1'b0, 1'b1);
        check_state("after_tmo");
        drain("tmo_rd");

        // Short clock glitches on an idle bus with data high must not strobe.
        i_ps2_data = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_ps2_clk = 1'b0; tick(2); i_ps2_clk = 1'b1; tick(8);
        end
        check_state("glitch");
        drive_bit(1'b1, 1'b0, 0, 0, 1'b0);
        tick(5);
        exp_frm++;
        check_state("bad_start");

        // Full FIFO, pop coinciding with the push.
        fill(8);
        tail = 8'($urandom_range(0, 8'hDF));
        send_frame(tail, 1'b0, 1'b1, 1'b0, lat, 0, 1'b0);
        h = exp_q.pop_front();
        model_frame(tail, 1'b0, 1'b1);
        check_state("full_pp");
        drain("full_pp_rd");

        // Prefix sequence.
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); model_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); model_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); model_frame(8'h74, 1'b0, 1'b1);
        check_state("prefix");
        drain("prefix_rd");

        // Random frames, errors, glitches and reads.
        for (int k = 0; k < 30; k++) begin
            d  = 8'($urandom_range(0, 255));
            e  = $urandom_range(0, 9);
            pf = (e == 0);
            st = (e == 1) ? 1'b0 : 1'b1;
            g  = 1'($urandom_range(0, 1));
            send_frame(d, pf, st, g, 0, 0, 1'b0);
            model_frame(d, pf, st);
            check_state("rnd");
            nr = $urandom_range(0, 2);
            for (int r = 0; r < nr; r++) if (exp_q.size() > 0) read_one("rnd_rd");
            if ($urandom_range(0, 7) == 0) begin
                i_ovf_clr = 1'b1; tick(1); i_ovf_clr = 1'b0;
                exp_ovf = 1'b0;
            end
        end
        drain("rnd_end");

        // Reset in the middle of a frame with data queued.
        fill(2);
        drive_bit(1'b0, 1'b0, 0, 0, 1'b0);
        drive_bit(1'b1, 1'b0, 0, 0, 1'b0);
        i_ps2_data = 1'b0;
        tick(HALF);
        i_ps2_clk = 1'b0;
        tick(3);
        i_clr_n = 1'b0;
        tick(2);
        model_reset();
        check_zero("rst_mid");
        i_ps2_clk = 1'b1; i_ps2_data = 1'b1;
        tick(3);
        i_clr_n = 1'b1;
        tick(10);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        model_frame(8'h5A, 1'b0, 1'b1);
        check_state("after_rst");
        drain("after_rst_rd");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver; successor to the single-mode 8-entry keyboard receiver.
- Adds input glitch filtering, a mid-frame timeout, error reporting, a ready/valid read port, a configurable FIFO depth and a level output.
- Sits between the PS/2 pins and the keyboard/scan-code consumer (display or CPU MMIO).

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of 2, >=2.
SYNC_STAGES, 2, metastability flops on ps2_clk and ps2_data; >=2.
FILTER_LEN, 4, consecutive equal synced samples needed before filtered ps2_clk changes.
TIMEOUT_CYC, 50000, i_clk cycles without a sample strobe, while mid-frame, before the frame is aborted.

Ports:
i_clk  in  1  system clock.
i_clr_n  in  1  reset, asynchronous, active-low.
i_ps2_clk  in  1  raw PS/2 clock, asynchronous.
i_ps2_data  in  1  raw PS/2 data, asynchronous.
i_ready  in  1  consumer accepts head byte.
i_ovf_clr  in  1  clears sticky overflow.
o_valid  out  1  FIFO non-empty.
o_data  out  8  head byte; 0 when empty.
o_ext  out  1  head byte preceded by E0 (decode option only, else 0).
o_brk  out  1  head byte preceded by F0 (decode option only, else 0).
o_level  out  $clog2(FIFO_DEPTH)+1  entries held.
o_overflow  out  1  sticky: a byte was dropped.
o_parity_err  out  1  one-cycle pulse.
o_frame_err  out  1  one-cycle pulse, bad start or stop bit.
o_timeout  out  1  one-cycle pulse.

Behaviour:
- Reset: all outputs 0, FSM IDLE, pointers 0, level 0. Sync flops and filtered clock reset to 1 (idle bus). Reset mid-frame discards the partial frame.
- Sync: SYNC_STAGES flops on each input.
- Filter: a counter compares the synced clock with the filtered clock; the filtered clock flips after FILTER_LEN consecutive differing samples. A 1->0 transition of the filtered clock produces a 1-cycle sample strobe; data is taken from the synced data line on that cycle.
- FSM:
  - IDLE: strobe with data=0 -> DATA; strobe with data=1 -> o_frame_err pulse, stay IDLE.
  - DATA: 8 strobes, LSB first -> PARITY.
  - PARITY: 1 strobe -> STOP.
  - STOP: on strobe, check odd parity over data+parity and stop bit=1.
    - Stop bad -> o_frame_err.
    - Else parity bad -> o_parity_err.
    - Else push the byte.
    - Always -> IDLE.
- Timeout: in any state other than IDLE, a counter counts cycles since the last strobe. At TIMEOUT_CYC -> o_timeout pulse, FSM to IDLE, bit count cleared.
- Latency: push occurs in the cycle after the stop strobe. o_valid and o_data update one cycle after the push.
- Read port:
  - The head byte is presented combinationally from storage.
  - A pop occurs when o_valid & i_ready.
  - i_ready while empty is ignored.
- Full:
  - Push while full with no pop: byte dropped, o_overflow set.
  - Push and pop in the same cycle while full: both take effect, level unchanged, no overflow.
- Overflow clear: i_ovf_clr clears o_overflow. If a set and a clear occur in the same cycle, the set wins.
- Level: +1 on push, -1 on pop, unchanged when both. Pointers wrap modulo FIFO_DEPTH. Count width is ADDR_W+1, so full = FIFO_DEPTH.

Optional Feature:
PS2_SCAN_DECODE_EN
- Defined:
  - FIFO entries are 10 bits wide.
  - A received E0 sets a pending-ext flag; a received F0 sets a pending-brk flag. Neither prefix is pushed.
  - The next non-prefix byte is pushed with {ext,brk} tags and both flags are cleared.
  - Flags also clear on timeout or frame error.
  - o_ext and o_brk reflect the head entry.
- Undefined: prefixes are pushed as plain bytes, o_ext and o_brk are tied 0, entries are 8 bits wide.

Decomposition:
- Package ps2_pkg holds:
  - the FSM state encoding (IDLE/DATA/PARITY/STOP);
  - PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0;
  - the frame bit count 11.
- Sub-module ps2_sync_fifo is parametrised on WIDTH and DEPTH. It provides push/pop/full/empty/level with same-cycle push+pop-when-full support.
- Sync, filter, FSM and timeout logic stay in the top module.

Test Plan:
- Send frame 0x1C with odd parity 0 and stop 1 -> o_valid rises, o_data=0x1C, o_level=1; pulse i_ready -> o_valid=0, o_level=0.
- Send 9 valid frames with FIFO_DEPTH=8 and i_ready=0 -> o_level=8, o_overflow=1, the first 8 bytes are read in order and the 9th is absent. i_ovf_clr -> o_overflow=0.
- Send frame 0x1C with parity bit flipped -> o_parity_err pulses once, o_valid stays 0. Send frame with stop=0 -> o_frame_err pulses once.
- Send start bit plus 4 data bits, then hold the clock high for TIMEOUT_CYC cycles -> o_timeout pulses. Next full frame 0x32 is received correctly.
- Inject 2-cycle low glitches on i_ps2_clk with FILTER_LEN=4 -> no strobes, no state change. With the FIFO full and i_ready=1 during a push -> level stays 8, no overflow.
- With PS2_SCAN_DECODE_EN, send E0,F0,74 -> single entry with o_data=0x74, o_ext=1, o_brk=1. Assert i_clr_n low mid-frame -> all outputs 0, FIFO empty.
